pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage SimpleRISC pipeline (IF, ID, EX, MEM, WB). It merges four hold sources into per-stage register enables and bubble/flush controls:
- memory wait,
- multi-cycle EX ops (mul/div/mod),
- taken branch,
- load-use stall request.

It owns the multi-cycle EX occupancy counter and a saturating stall-cycle performance counter. It sits beside the pipeline registers and consumes add_stall from the load-use detector.

Parameters:
MUL_LAT, 3, total EX cycles for mul (opcode 5'b00010); legal 1..15
DIV_LAT, 8, total EX cycles for div/mod (opcodes 5'b00011, 5'b00100); legal 1..15
CNT_W, 4, width of occupancy counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
instruction_E  input  32  instruction in EX; opcode [31:27]
instruction_M  input  32  instruction in MEM; opcode [31:27]
add_stall  input  1  load-use stall request from hazard detector
isBranchTaken_E  input  1  branch in EX resolved taken
mem_ready  input  1  data memory ready; meaningful only for ld (01110) / st (01111) in M
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage register enables
if_id_flush  output  1  load nop into IF/ID
id_ex_bubble, ex_mem_bubble, mem_wb_bubble  output  1 each  load nop into that register
ex_busy  output  1  multi-cycle op holding EX
stall_cycles  output  16  saturating count of cycles with pc_en=0

Behaviour:
- Reset is asynchronous:
  - state=RUN, cnt=0, mc_done=0, stall_cycles=0.
  - While rst_n=0, all *_en=0, all flush/bubble=0, ex_busy=0.
  - Reset mid-MC_BUSY aborts to RUN with mc_done=0.
- States: RUN, MC_BUSY.
  - Registers: cnt[CNT_W-1:0]; mc_done flag, meaning the current EX op already finished its occupancy.
- Hold sources:
  - lat = MUL_LAT for mul, DIV_LAT for div/mod.
  - mc_start = state==RUN & opcode_E in {mul,div,mod} & !mc_done & lat>1.
  - mc_hold = mc_start | state==MC_BUSY.
  - mem_hold = opcode_M in {ld,st} & !mem_ready.
- Sequencing:
  - On mc_start: cnt<=lat-2. If lat==2, stay RUN and set mc_done<=1; otherwise go to MC_BUSY.
  - In MC_BUSY: cnt<=cnt-1. When cnt==1, go to RUN and set mc_done<=1.
  - Total freeze = lat-1 cycles, so the op occupies EX for exactly lat cycles. The counter runs regardless of mem_hold.
  - mc_done clears on any clock where id_ex_en=1.
  - lat==1 ops never hold.
- Output priority (combinational from state and inputs, highest first):
  1. mem_hold: pc_en=if_id_en=id_ex_en=ex_mem_en=0; mem_wb_en=1, mem_wb_bubble=1.
  2. mc_hold: pc_en=if_id_en=id_ex_en=0; ex_mem_en=1, ex_mem_bubble=1; mem_wb_en=1.
  3. isBranchTaken_E: all en=1; if_id_flush=1, id_ex_bubble=1. This overrides add_stall because the stalled D instruction is squashed.
  4. add_stall: pc_en=if_id_en=0; id_ex_en=1, id_ex_bubble=1; ex_mem_en=mem_wb_en=1.
  5. Otherwise all en=1, all flush/bubble=0.
- Bubble/flush signals are never asserted on a register whose enable is 0.
- ex_busy = mc_hold. It is asserted even when mem_hold wins priority.
- stall_cycles: increments on each clock with rst_n=1 and pc_en=0; saturates at 16'hFFFF; no wrap.

Test Plan:
1. mul r3,r1,r2 (E=0x10C48000), MUL_LAT=3, mem idle -> pc_en=0 and ex_mem_bubble=1 for exactly 2 cycles; ex_busy for 2 cycles; 3rd cycle all en=1; no re-trigger while E still holds 0x10C48000; stall_cycles=2.
2. div (E=0x18C48000), DIV_LAT=8, with mem_ready=0 and ld in M (0x70000000) during cycles 3-4 -> freeze persists; mem_wb_bubble=1 in cycles 3-4; total freeze 7 cycles (counter unaffected); release cycle 8.
3. add_stall=1 and isBranchTaken_E=1 same cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1; add_stall alone -> pc_en=0, if_id_en=0, id_ex_bubble=1.
4. rst_n low at cycle 2 of a DIV_LAT=8 hold -> outputs 0 immediately (async); after release with nop in E (0x68000000), state RUN, all en=1, stall_cycles=0.
5. Force mem_ready=0 with st in M for 70000 cycles -> stall_cycles stops at 16'hFFFF.
6. MUL_LAT=1 override, mul in E -> no hold, ex_busy=0; MUL_LAT=2 -> single-cycle freeze.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the SimpleRISC pipeline and its stall/flush sequencer.
// master = pipeline side (drives instructions and hold requests),
// slave  = sequencer side (drives enables, bubbles and status).
interface pipeline_stall_ctrl_if;
    logic [31:0] instruction_E;
    logic [31:0] instruction_M;
    logic        add_stall;
    logic        isBranchTaken_E;
    logic        mem_ready;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        mem_wb_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_bubble;
    logic        mem_wb_bubble;
    logic        ex_busy;
    logic [15:0] stall_cycles;

    modport master (
        output instruction_E, instruction_M, add_stall, isBranchTaken_E, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
        input  ex_busy, stall_cycles
    );

    modport slave (
        input  instruction_E, instruction_M, add_stall, isBranchTaken_E, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
        output ex_busy, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait,
// multi-cycle EX occupancy, taken branch and load-use stall into per-stage
// enables and bubble/flush controls, and counts frozen-PC cycles.
module pipeline_stall_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_stall_ctrl_if.slave  bus
);
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_MOD = 5'b00100;
    localparam logic [4:0] OP_LD  = 5'b01110;
    localparam logic [4:0] OP_ST  = 5'b01111;

    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_mc_done, w_mc_done_nxt;
    logic [15:0]      r_stall_cycles;

    logic [4:0]       w_op_E, w_op_M;
    logic [CNT_W-1:0] w_lat;
    logic             w_is_mc, w_mc_start, w_mc_hold, w_mem_hold;
    logic             w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
    logic             w_if_id_flush, w_id_ex_bubble, w_ex_mem_bubble, w_mem_wb_bubble;
    logic             w_unused_bits;

    assign w_op_E = bus.instruction_E[31:27];
    assign w_op_M = bus.instruction_M[31:27];
    assign w_unused_bits = ^{bus.instruction_E[26:0], bus.instruction_M[26:0]};

    // Latency lookup for the op currently in EX; non-multi-cycle ops count as 1.
    always_comb begin
        w_lat   = CNT_W'(1);
        w_is_mc = 1'b0;
        case (w_op_E)
            OP_MUL: begin
                w_lat   = CNT_W'(MUL_LAT);
                w_is_mc = 1'b1;
            end
            OP_DIV, OP_MOD: begin
                w_lat   = CNT_W'(DIV_LAT);
                w_is_mc = 1'b1;
            end
            default: ;
        endcase
    end

    // A mc op starts only once per EX residency; mc_done blocks re-trigger on release.
    assign w_mc_start = (r_state == RUN) && w_is_mc && !r_mc_done && (w_lat > CNT_W'(1));
    assign w_mc_hold  = w_mc_start || (r_state == MC_BUSY);
    assign w_mem_hold = ((w_op_M == OP_LD) || (w_op_M == OP_ST)) && !bus.mem_ready;

    // Next-state / occupancy counter; the counter ignores mem_hold so EX time is fixed.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_mc_done_nxt = r_mc_done;
        if (w_id_ex_en)
            w_mc_done_nxt = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mc_start) begin
                    w_cnt_nxt = w_lat - CNT_W'(2);
                    if (w_lat == CNT_W'(2))
                        w_mc_done_nxt = 1'b1;
                    else
                        w_state_nxt = MC_BUSY;
                end
            end
            MC_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt   = RUN;
                    w_mc_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Priority merge of hold sources into enables; everything low while in reset.
    always_comb begin
        w_pc_en         = 1'b0;
        w_if_id_en      = 1'b0;
        w_id_ex_en      = 1'b0;
        w_ex_mem_en     = 1'b0;
        w_mem_wb_en     = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_bubble  = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_mem_wb_bubble = 1'b0;
        if (rst_n) begin
            if (w_mem_hold) begin
                w_mem_wb_en     = 1'b1;
                w_mem_wb_bubble = 1'b1;
            end else if (w_mc_hold) begin
                w_ex_mem_en     = 1'b1;
                w_ex_mem_bubble = 1'b1;
                w_mem_wb_en     = 1'b1;
            end else if (bus.isBranchTaken_E) begin
                // The load-use-stalled D instruction is squashed, so the branch wins.
                {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '1;
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (bus.add_stall) begin
                w_id_ex_en     = 1'b1;
                w_id_ex_bubble = 1'b1;
                w_ex_mem_en    = 1'b1;
                w_mem_wb_en    = 1'b1;
            end else begin
                {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = '1;
            end
        end
    end

    // FSM state, occupancy counter and done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mc_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mc_done <= w_mc_done_nxt;
        end
    end

    // Saturating count of cycles with the PC frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cycles <= '0;
        else if (!w_pc_en && (r_stall_cycles != 16'hFFFF))
            r_stall_cycles <= r_stall_cycles + 16'd1;
    end

    assign bus.pc_en         = w_pc_en;
    assign bus.if_id_en      = w_if_id_en;
    assign bus.id_ex_en      = w_id_ex_en;
    assign bus.ex_mem_en     = w_ex_mem_en;
    assign bus.mem_wb_en     = w_mem_wb_en;
    assign bus.if_id_flush   = w_if_id_flush;
    assign bus.id_ex_bubble  = w_id_ex_bubble;
    assign bus.ex_mem_bubble = w_ex_mem_bubble;
    assign bus.mem_wb_bubble = w_mem_wb_bubble;
    assign bus.ex_busy       = rst_n && w_mc_hold;
    assign bus.stall_cycles  = r_stall_cycles;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: three instances (MUL_LAT 3/1/2) driven in
// lockstep, each with its own EX instruction that advances only when the
// instance loads ID/EX. Expected outputs come from a residency-age model.
module tb_pipeline_stall_ctrl;
    localparam logic [31:0] I_MUL = 32'h10C48000;
    localparam logic [31:0] I_DIV = 32'h18C48000;
    localparam logic [31:0] I_MOD = 32'h20C48000;
    localparam logic [31:0] I_NOP = 32'h68000000;
    localparam logic [31:0] I_ADD = 32'h00C48000;
    localparam logic [31:0] I_LD  = 32'h70000000;
    localparam logic [31:0] I_ST  = 32'h78000000;
    localparam int DIV_L = 8;
    localparam int MLAT [3] = '{3, 1, 2};

    typedef struct packed {
        logic [4:0]  en;     // pc, if_id, id_ex, ex_mem, mem_wb
        logic        flush;
        logic [2:0]  bub;    // id_ex, ex_mem, mem_wb
        logic        busy;
        logic [15:0] stall;
    } one_t;
    typedef one_t [2:0] trio_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instE [3];
    logic [31:0] instM;
    logic        add_stall, br_taken, mem_ready;
    logic [31:0] e_feed;
    one_t        act [3];
    trio_t       sbq [$];
    int          age [3];
    logic [15:0] sc [3];
    int          tests = 0, fails = 0, cyc = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if b0 ();
    pipeline_stall_ctrl_if b1 ();
    pipeline_stall_ctrl_if b2 ();

    pipeline_stall_ctrl #(.MUL_LAT(3), .DIV_LAT(DIV_L), .CNT_W(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pipeline_stall_ctrl #(.MUL_LAT(1), .DIV_LAT(DIV_L), .CNT_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pipeline_stall_ctrl #(.MUL_LAT(2), .DIV_LAT(DIV_L), .CNT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    assign b0.instruction_E = instE[0];
    assign b1.instruction_E = instE[1];
    assign b2.instruction_E = instE[2];
    assign {b0.instruction_M, b1.instruction_M, b2.instruction_M} = {3{instM}};
    assign {b0.add_stall, b1.add_stall, b2.add_stall} = {3{add_stall}};
    assign {b0.isBranchTaken_E, b1.isBranchTaken_E, b2.isBranchTaken_E} = {3{br_taken}};
    assign {b0.mem_ready, b1.mem_ready, b2.mem_ready} = {3{mem_ready}};

    assign act[0] = {b0.pc_en, b0.if_id_en, b0.id_ex_en, b0.ex_mem_en, b0.mem_wb_en, b0.if_id_flush,
                     b0.id_ex_bubble, b0.ex_mem_bubble, b0.mem_wb_bubble, b0.ex_busy, b0.stall_cycles};
    assign act[1] = {b1.pc_en, b1.if_id_en, b1.id_ex_en, b1.ex_mem_en, b1.mem_wb_en, b1.if_id_flush,
                     b1.id_ex_bubble, b1.ex_mem_bubble, b1.mem_wb_bubble, b1.ex_busy, b1.stall_cycles};
    assign act[2] = {b2.pc_en, b2.if_id_en, b2.id_ex_en, b2.ex_mem_en, b2.mem_wb_en, b2.if_id_flush,
                     b2.id_ex_bubble, b2.ex_mem_bubble, b2.mem_wb_bubble, b2.ex_busy, b2.stall_cycles};

    // Reference: a multi-cycle op of latency L keeps EX frozen while it has
    // spent fewer than L-1 clocks there; the rest is a fixed priority ladder.
    function automatic one_t model(input int mlat, input int a, input logic [31:0] e, input logic [31:0] m,
                                   input logic as_i, input logic br_i, input logic mr_i, input logic rn_i,
                                   input logic [15:0] s);
        one_t r;
        int   lat;
        logic mch, memh;
        r = '0;
        r.stall = s;
        if (!rn_i) return r;
        case (e[31:27])
            5'd2:       lat = mlat;
            5'd3, 5'd4: lat = DIV_L;
            default:    lat = 1;
        endcase
        mch  = a < lat - 1;
        memh = (m[31:27] == 5'd14 || m[31:27] == 5'd15) && !mr_i;
        r.busy = mch;
        if (memh)      begin r.en = 5'b00001; r.bub = 3'b001; end
        else if (mch)  begin r.en = 5'b00011; r.bub = 3'b010; end
        else if (br_i) begin r.en = 5'b11111; r.flush = 1'b1; r.bub = 3'b100; end
        else if (as_i) begin r.en = 5'b00111; r.bub = 3'b100; end
        else             r.en = 5'b11111;
        return r;
    endfunction

    // One clock: drive inputs, queue expectations, advance the modelled pipeline.
    task automatic step(input logic [31:0] m, input logic as_i, input logic br_i, input logic mr_i, input logic rn_i);
        trio_t x;
        rst_n = rn_i; instM = m; add_stall = as_i; br_taken = br_i; mem_ready = mr_i;
        for (int d = 0; d < 3; d++) begin
            if (!rn_i) begin age[d] = 0; sc[d] = 16'd0; end
            x[d] = model(MLAT[d], age[d], instE[d], m, as_i, br_i, mr_i, rn_i, sc[d]);
        end
        sbq.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
        if (rn_i) begin
            for (int d = 0; d < 3; d++) begin
                if (!x[d].en[4] && sc[d] != 16'hFFFF) sc[d] = sc[d] + 16'd1;
                if (x[d].en[2]) begin
                    age[d]  = 0;
                    instE[d] = x[d].bub[2] ? I_NOP : e_feed;
                end else if (age[d] < 1000) begin
                    age[d] = age[d] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Monitor: each negedge the DUTs present a full output set; compare against the queue head.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            trio_t x;
            x = sbq.pop_front();
            for (int d = 0; d < 3; d++) begin
                tests++;
                if (act[d] !== x[d]) begin
                    fails++;
                    $display("FAIL outputs dut%0d cyc%0d: got en=%b fl=%b bub=%b busy=%b stall=%0d expected en=%b fl=%b bub=%b busy=%b stall=%0d",
                             d, cyc, act[d].en, act[d].flush, act[d].bub, act[d].busy, act[d].stall,
                             x[d].en, x[d].flush, x[d].bub, x[d].busy, x[d].stall);
                end
            end
        end
    end

    logic [31:0] epool [6];

    initial begin
        epool = '{I_MUL, I_DIV, I_MOD, I_NOP, I_ADD, I_LD};
        rst_n = 1'b0; instM = I_NOP; add_stall = 1'b0; br_taken = 1'b0; mem_ready = 1'b1;
        e_feed = I_NOP;
        for (int d = 0; d < 3; d++) begin instE[d] = I_NOP; age[d] = 0; sc[d] = 16'd0; end
        @(posedge clk); #1;
        step(I_NOP, 0, 0, 1, 0);                       // reset state
        repeat (2) step(I_NOP, 0, 0, 1, 1);

        // mul: 2-cycle freeze at MUL_LAT=3, none at 1, one at 2
        e_feed = I_MUL;
        step(I_NOP, 0, 0, 1, 1);
        e_feed = I_NOP;
        repeat (5) step(I_NOP, 0, 0, 1, 1);
        chk("mul_stall_lat3", act[0].stall, 16'd2);
        chk("mul_stall_lat1", act[1].stall, 16'd0);
        chk("mul_stall_lat2", act[2].stall, 16'd1);

        // div with a memory wait in hold cycles 3-4: freeze still 7 cycles
        e_feed = I_DIV;
        step(I_NOP, 0, 0, 1, 1);
        e_feed = I_NOP;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3 || c == 4) step(I_LD, 0, 0, 0, 1);
            else                  step(I_NOP, 0, 0, 1, 1);
        end
        chk("div_stall_total", act[0].stall, 16'd9);

        // branch beats load-use, then load-use alone
        step(I_NOP, 1, 1, 1, 1);
        step(I_NOP, 1, 0, 1, 1);
        step(I_NOP, 0, 0, 1, 1);

        // reset in cycle 2 of a div hold
        e_feed = I_DIV;
        step(I_NOP, 0, 0, 1, 1);
        e_feed = I_NOP;
        step(I_NOP, 0, 0, 1, 1);
        step(I_NOP, 0, 0, 1, 0);
        for (int d = 0; d < 3; d++) instE[d] = I_NOP;
        step(I_NOP, 0, 0, 1, 1);
        chk("post_reset_stall", act[0].stall, 16'd0);
        chk("post_reset_pc_en", {15'd0, act[0].en[4]}, 16'd1);

        // stall counter saturation
        repeat (65540) step(I_ST, 0, 0, 0, 1);
        chk("stall_sat", act[0].stall, 16'hFFFF);
        step(I_ST, 0, 0, 0, 1);
        chk("stall_no_wrap", act[2].stall, 16'hFFFF);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] m;
            e_feed = epool[$urandom_range(0, 5)];
            case ($urandom_range(0, 2))
                0:       m = I_LD;
                1:       m = I_ST;
                default: m = I_ADD;
            endcase
            step(m, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
        end

        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
